// File: rtl/qerv_ibus_mem.sv
// rtl/qerv_ibus_mem.sv - Wishbone instruction-bus responder backed by on-chip memory
// Optional one-entry sequential prefetch buffer enabled by QERV_IBUS_PREFETCH_EN.
`timescale 1ns/1ps
module qerv_ibus_mem #(
  parameter int DEPTH       = 256,
  parameter int AW          = $clog2(DEPTH),
  parameter int WAIT_STATES = 1,
  parameter     MEMFILE     = ""
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_adr,
  input  logic [31:0]   i_ld_dat
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_ACK} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0]   mem [DEPTH];
  state_t        state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic [3:0]    cnt, cnt_d;
  logic          ack_d;
  logic [31:0]   rdt_d;
  logic [AW-1:0] adr_idx;
  logic          unused_adr;

  assign adr_idx    = i_ibus_adr[AW+1:2];
  assign unused_adr = ^{i_ibus_adr[31:AW+2], i_ibus_adr[1:0]};

  // Nonblocking write gives read-before-write against a same-edge read.
  always_ff @(posedge clk) begin
    if (i_ld_en) mem[i_ld_adr] <= i_ld_dat;
  end

`ifdef QERV_IBUS_PREFETCH_EN
  logic          pf_valid, pf_valid_d;
  logic [AW-1:0] pf_idx, pf_idx_d;
  logic [31:0]   pf_buf, pf_buf_d;
  logic [AW-1:0] idx_inc;

  assign idx_inc = idx + 1'b1;
`endif

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    ack_d   = 1'b0;
    rdt_d   = o_ibus_rdt;
`ifdef QERV_IBUS_PREFETCH_EN
    pf_valid_d = pf_valid;
    pf_idx_d   = pf_idx;
    pf_buf_d   = pf_buf;
`endif
    case (state)
      S_IDLE: begin
        if (i_ibus_cyc) begin
          idx_d = adr_idx;
`ifdef QERV_IBUS_PREFETCH_EN
          if (pf_valid && adr_idx == pf_idx) begin
            rdt_d   = pf_buf;
            ack_d   = 1'b1;
            state_d = S_ACK;
          end else
`endif
          if (WAIT_STATES > 0) begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WAIT: begin
        if (!i_ibus_cyc)   state_d = S_IDLE;
        else if (cnt == 0) state_d = S_READ;
        else               cnt_d   = cnt - 4'd1;
      end
      S_READ: begin
        if (!i_ibus_cyc) begin
          state_d = S_IDLE;
        end else begin
          rdt_d   = mem[idx];
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
`ifdef QERV_IBUS_PREFETCH_EN
        pf_buf_d   = mem[idx_inc];
        pf_idx_d   = idx_inc;
        pf_valid_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef QERV_IBUS_PREFETCH_EN
    // Also covers a load landing on the word being prefetched this edge.
    if (i_ld_en && i_ld_adr == pf_idx_d) pf_valid_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      o_ibus_ack <= 1'b0;
      o_ibus_rdt <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      o_ibus_ack <= ack_d;
      o_ibus_rdt <= rdt_d;
    end
  end

`ifdef QERV_IBUS_PREFETCH_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pf_valid <= 1'b0;
      pf_idx   <= '0;
      pf_buf   <= '0;
    end else begin
      pf_valid <= pf_valid_d;
      pf_idx   <= pf_idx_d;
      pf_buf   <= pf_buf_d;
    end
  end
`endif

endmodule

// File: tb/tb_qerv_ibus_mem.sv
// tb/tb_qerv_ibus_mem.sv - self-checking bench for qerv_ibus_mem
`timescale 1ns/1ps
module tb_qerv_ibus_mem;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int WS    = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   ibus_adr;
  logic          ibus_cyc;
  logic [31:0]   ibus_rdt;
  logic          ibus_ack;
  logic          ld_en;
  logic [AW-1:0] ld_adr;
  logic [31:0]   ld_dat;

  always #5 clk = ~clk;

  qerv_ibus_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .i_rst_n   (rst_n),
    .i_ibus_adr(ibus_adr),
    .i_ibus_cyc(ibus_cyc),
    .o_ibus_rdt(ibus_rdt),
    .o_ibus_ack(ibus_ack),
    .i_ld_en   (ld_en),
    .i_ld_adr  (ld_adr),
    .i_ld_dat  (ld_dat)
  );

  int          npass = 0;
  int          nfail = 0;
  logic [31:0] mdl_mem [DEPTH];
  bit          pf_v;
  int          pf_i;
  int          last_idx;
  logic [31:0] last_rdt;

  function automatic int widx(logic [31:0] a);
    return int'(a >> 2) % DEPTH;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic load(int a, logic [31:0] d);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_adr = AW'(a);
    ld_dat = d;
    @(negedge clk);
    ld_en  = 1'b0;
    mdl_mem[a] = d;
    if (pf_v && pf_i == a) pf_v = 1'b0;
  endtask

  task automatic read_word(string tag, logic [31:0] adr);
    int idx;
    int exp_lat;
    int lat;
    bit got;
    idx     = widx(adr);
    exp_lat = WS + 2;
    lat     = 0;
    got     = 1'b0;
`ifdef QERV_IBUS_PREFETCH_EN
    if (pf_v && pf_i == idx) exp_lat = 1;
`endif
    @(negedge clk);
    ibus_adr = adr;
    ibus_cyc = 1'b1;
    while (!got && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      got = ibus_ack;
    end
    check({tag, ".ack"}, 32'(got), 32'd1);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".rdt"}, ibus_rdt, mdl_mem[idx]);
    @(negedge clk);
    ibus_cyc = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".one_ack"}, 32'(ibus_ack), 32'd0);
    check({tag, ".hold"}, ibus_rdt, mdl_mem[idx]);
    last_rdt = mdl_mem[idx];
    last_idx = idx;
`ifdef QERV_IBUS_PREFETCH_EN
    pf_v = 1'b1;
    pf_i = (idx + 1) % DEPTH;
`endif
  endtask

  task automatic count_acks(string tag, int cycles);
    int acks;
    acks = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (ibus_ack) acks++;
    end
    check(tag, acks, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    ibus_cyc = 1'b0;
    ibus_adr = '0;
    ld_en    = 1'b0;
    ld_adr   = '0;
    ld_dat   = '0;
    pf_v     = 1'b0;
    pf_i     = 0;
    last_idx = 0;
    last_rdt = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset.ack", 32'(ibus_ack), 32'd0);
    check("reset.rdt", ibus_rdt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    load(0, 32'h00000013);
    load(1, 32'h00100093);
    load(2, 32'h00200113);
    load(3, 32'h00300193);

    read_word("first", 32'h0);
    read_word("alias404", 32'h404);
    read_word("alias006", 32'h6);

    // Rewriting index 2 drops any prefetch so the abort below takes the slow path.
    load(2, 32'h00200113);
    @(negedge clk);
    ibus_adr = 32'h8;
    ibus_cyc = 1'b1;
    @(negedge clk);
    ibus_cyc = 1'b0;
    count_acks("abort.noack", 8);
    check("abort.rdt", ibus_rdt, last_rdt);
    read_word("after_abort", 32'hC);
    check("after_abort.val", last_rdt, 32'h00300193);

    @(negedge clk);
    ibus_adr = 32'h8;
    ibus_cyc = 1'b1;
    repeat (WS + 1) @(negedge clk);
    ld_en  = 1'b1;
    ld_adr = AW'(2);
    ld_dat = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    check("collide.ack", 32'(ibus_ack), 32'd1);
    check("collide.rdt", ibus_rdt, 32'h00200113);
    @(negedge clk);
    ld_en    = 1'b0;
    ibus_cyc = 1'b0;
    mdl_mem[2] = 32'hDEADBEEF;
    last_rdt   = 32'h00200113;
`ifdef QERV_IBUS_PREFETCH_EN
    pf_v = 1'b1;
    pf_i = 3;
`endif
    @(posedge clk);
    #1;
    check("collide.one_ack", 32'(ibus_ack), 32'd0);
    read_word("post_collide", 32'h8);
    check("post_collide.val", last_rdt, 32'hDEADBEEF);

    read_word("seq0", 32'h0);
    read_word("seq4", 32'h4);
    load(2, 32'h12345678);
    read_word("load_then8", 32'h8);
    read_word("seq4b", 32'h4);
    read_word("jump10", 32'h10);

    @(negedge clk);
    ibus_adr = 32'h4;
    ibus_cyc = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid.ack", 32'(ibus_ack), 32'd0);
    check("rst_mid.rdt", ibus_rdt, 32'd0);
    ibus_cyc = 1'b0;
    pf_v     = 1'b0;
    last_rdt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_acks("rst_mid.noack", 8);

    for (int n = 0; n < 80; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      if (op == 0) begin
        load($urandom_range(0, DEPTH - 1), $urandom);
      end else begin
        a = $urandom;
        if (op != 1) a = {a[31:AW+2], AW'((last_idx + 1) % DEPTH), a[1:0]};
        read_word($sformatf("rand%0d", n), a);
      end
    end

    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end

endmodule
